// File: rtl/bloco_operativo_pkg.sv
// Shared constants for the bloco_operativo datapath and its control FSM.
// Holds the operand / S-write mux encodings and the ALU op encoding, so both
// blocks agree on what M0/M1/M2/H mean.
package bloco_operativo_pkg;

  // Operand A select (M0)
  typedef enum logic [1:0] {
    SEL_A_X    = 2'd0,
    SEL_A_H    = 2'd1,
    SEL_A_S    = 2'd2,
    SEL_A_COEF = 2'd3
  } sel_a_e;

  // Operand B select (M1)
  typedef enum logic [1:0] {
    SEL_B_COEF = 2'd0,
    SEL_B_X    = 2'd1,
    SEL_B_H    = 2'd2,
    SEL_B_S    = 2'd3
  } sel_b_e;

  // S write-data select (M2); codes 0 and 2 both route the ALU
  typedef enum logic [1:0] {
    SEL_S_ALU  = 2'd0,
    SEL_S_COEF = 2'd1,
    SEL_S_ALU2 = 2'd2,
    SEL_S_XIN  = 2'd3
  } sel_s_e;

  localparam logic OP_MUL = 1'b1;
  localparam logic OP_ADD = 1'b0;

  // True when the given M2 code writes the ALU result into S
  function automatic logic s_from_alu(input logic [1:0] m2);
    return (m2 == SEL_S_ALU) || (m2 == SEL_S_ALU2);
  endfunction

endpackage

// File: rtl/bloco_operativo_if.sv
// Bundle between the control block (master) and the datapath (slave):
// operands/constants, mux selects, load enables, ALU op, pronto, and the
// result valid/ack handshake plus the overflow flag going back.
interface bloco_operativo_if #(parameter int W = 8);
  logic [W-1:0] x_in;
  logic [W-1:0] coef_a;
  logic [W-1:0] coef_b;
  logic [W-1:0] coef_c;
  logic [1:0]   M0;
  logic [1:0]   M1;
  logic [1:0]   M2;
  logic         LX;
  logic         LH;
  logic         LS;
  logic         H;
  logic         pronto;
  logic         res_ack;
  logic [W-1:0] resultado;
  logic         res_valid;
  logic         ovf;

  modport master (
    output x_in, coef_a, coef_b, coef_c, M0, M1, M2, LX, LH, LS, H, pronto, res_ack,
    input  resultado, res_valid, ovf
  );

  modport slave (
    input  x_in, coef_a, coef_b, coef_c, M0, M1, M2, LX, LH, LS, H, pronto, res_ack,
    output resultado, res_valid, ovf
  );
endinterface

// File: rtl/bloco_operativo_ula_mul_soma.sv
// ula_mul_soma: combinational unsigned add/multiply shared by H and S.
//   a, b : operands (W bits)
//   op   : OP_MUL / OP_ADD
//   y    : low W bits of the result (wraps modulo 2^W)
//   ovf  : product upper half nonzero, or carry out of the sum
module ula_mul_soma
  import bloco_operativo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [2*W-1:0] prod;
  logic [W:0]     sum;

  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign sum  = {1'b0, a} + {1'b0, b};

  always_comb begin
    y   = sum[W-1:0];
    ovf = sum[W];
    if (op == OP_MUL) begin
      y   = prod[W-1:0];
      ovf = |prod[2*W-1:W];
    end
  end

endmodule

// File: rtl/bloco_operativo.sv
// bloco_operativo: datapath stage sequenced by the external control FSM.
// Working registers X/H/S, one shared add/multiply unit, a sticky overflow
// flag and a result register handed downstream with valid/ack.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bloco_operativo_if (controls in, result out)
module bloco_operativo
  import bloco_operativo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  bloco_operativo_if.slave  bus
);

  logic [W-1:0] reg_x, reg_h, reg_s;
  logic [W-1:0] alu_a, alu_b, alu_y, s_wdata;
  logic         alu_ovf, ovf_set;
  logic [W-1:0] res_q;
  logic         valid_q, ovf_q;

  always_comb begin
    alu_a = reg_x;
    case (bus.M0)
      SEL_A_H:    alu_a = reg_h;
      SEL_A_S:    alu_a = reg_s;
      SEL_A_COEF: alu_a = bus.coef_a;
      default:    alu_a = reg_x;
    endcase
  end

  always_comb begin
    alu_b = bus.coef_c;
    case (bus.M1)
      SEL_B_X: alu_b = reg_x;
      SEL_B_H: alu_b = reg_h;
      SEL_B_S: alu_b = reg_s;
      default: alu_b = bus.coef_c;
    endcase
  end

  ula_mul_soma #(.W(W)) u_ula (
    .a   (alu_a),
    .b   (alu_b),
    .op  (bus.H),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  always_comb begin
    s_wdata = alu_y;
    case (bus.M2)
      SEL_S_COEF: s_wdata = bus.coef_b;
      SEL_S_XIN:  s_wdata = bus.x_in;
      default:    s_wdata = alu_y;
    endcase
  end

  // Only an ALU value actually being written can raise the flag
  assign ovf_set = alu_ovf && (bus.LH || (bus.LS && s_from_alu(bus.M2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_x <= '0;
      reg_h <= '0;
      reg_s <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.LX) reg_x <= bus.x_in;
      if (bus.LH) reg_h <= alu_y;
      if (bus.LS) reg_s <= s_wdata;
      // LX starts a new computation; a same-cycle overflow still wins
      if (ovf_set)     ovf_q <= 1'b1;
      else if (bus.LX) ovf_q <= 1'b0;
    end
  end

  // Capture is refused while an unacked result is pending (value dropped);
  // an ack in the capture cycle frees the slot for the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.pronto && (!valid_q || bus.res_ack)) begin
      res_q   <= reg_s;
      valid_q <= 1'b1;
    end else if (bus.res_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.resultado = res_q;
  assign bus.res_valid = valid_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bloco_operativo.sv
// Directed bench for bloco_operativo: a per-cycle arithmetic model is
// compared against the DUT every negedge, and literal expectations at the
// key points of each scenario pin the model itself.
module tb_bloco_operativo;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bloco_operativo_if #(.W(W)) bus ();

  bloco_operativo #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic, updated on each rising edge
  int mx, mh, ms, mres, mv, movf;
  int ma, mb, mr, msd;
  bit mro;

  always @(posedge clk) begin
    if (rst) begin
      mx = 0; mh = 0; ms = 0; mres = 0; mv = 0; movf = 0;
    end else begin
      case (bus.M0)
        2'd0: ma = mx;
        2'd1: ma = mh;
        2'd2: ma = ms;
        default: ma = int'(bus.coef_a);
      endcase
      case (bus.M1)
        2'd0: mb = int'(bus.coef_c);
        2'd1: mb = mx;
        2'd2: mb = mh;
        default: mb = ms;
      endcase
      mr  = bus.H ? ma * mb : ma + mb;
      mro = (mr > 255);
      mr  = mr % 256;
      msd = (bus.M2 == 2'd1) ? int'(bus.coef_b) : (bus.M2 == 2'd3) ? int'(bus.x_in) : mr;
      if (bus.pronto && (mv == 0 || bus.res_ack)) begin
        mres = ms; mv = 1;
      end else if (bus.res_ack) begin
        mv = 0;
      end
      if (mro && (bus.LH || (bus.LS && (bus.M2 == 2'd0 || bus.M2 == 2'd2)))) movf = 1;
      else if (bus.LX) movf = 0;
      if (bus.LX) mx = int'(bus.x_in);
      if (bus.LH) mh = mr;
      if (bus.LS) ms = msd;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_regX", int'(dut.reg_x), mx);
      chk("cyc_regH", int'(dut.reg_h), mh);
      chk("cyc_regS", int'(dut.reg_s), ms);
      chk("cyc_resultado", int'(bus.resultado), mres);
      chk("cyc_res_valid", int'(bus.res_valid), mv);
      chk("cyc_ovf", int'(bus.ovf), movf);
    end
  end

  task automatic idle();
    bus.LX = 0; bus.LH = 0; bus.LS = 0; bus.pronto = 0; bus.res_ack = 0;
  endtask

  // One clock: inputs set before the call are sampled at this edge
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_x(input int v);
    bus.x_in = v[W-1:0]; bus.LX = 1; step();
  endtask

  // Nominal steps 1..4 (regX=3, regH=9, regS=5, regH=15)
  task automatic nominal_1_4();
    load_x(3);
    chk("n1_regX", int'(dut.reg_x), 3);
    bus.M0 = 2'd0; bus.M1 = 2'd1; bus.H = 1; bus.LH = 1; step();
    chk("n2_regH", int'(dut.reg_h), 9);
    bus.M2 = 2'd1; bus.coef_b = 8'd5; bus.LS = 1; step();
    chk("n3_regS", int'(dut.reg_s), 5);
    bus.M0 = 2'd2; bus.M1 = 2'd1; bus.H = 1; bus.LH = 1; step();
    chk("n4_regH", int'(dut.reg_h), 15);
  endtask

  task automatic nominal_5_6();
    bus.M0 = 2'd1; bus.M1 = 2'd3; bus.H = 0; bus.M2 = 2'd0; bus.LS = 1; step();
    chk("n5_regS", int'(dut.reg_s), 20);
    bus.pronto = 1; step();
    chk("n6_resultado", int'(bus.resultado), 20);
    chk("n6_res_valid", int'(bus.res_valid), 1);
    chk("n6_ovf", int'(bus.ovf), 0);
  endtask

  initial begin
    idle();
    bus.x_in = 0; bus.coef_a = 8'd11; bus.coef_b = 0; bus.coef_c = 8'd2;
    bus.M0 = 0; bus.M1 = 0; bus.M2 = 0; bus.H = 0;
    // Reset with loads and pronto active: reset must win
    rst = 1; bus.x_in = 8'd77; bus.LX = 1; bus.LH = 1; bus.LS = 1; bus.pronto = 1;
    step();
    rst = 0; cmp_en = 1;
    chk("rst_regX", int'(dut.reg_x), 0);
    chk("rst_regS", int'(dut.reg_s), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_ovf", int'(bus.ovf), 0);

    nominal_1_4();
    nominal_5_6();
    bus.res_ack = 1; step();
    chk("ack_clears_valid", int'(bus.res_valid), 0);

    // Overflow: 20*20 = 400 -> 144, sticky until next LX
    load_x(20);
    bus.M0 = 2'd0; bus.M1 = 2'd1; bus.H = 1; bus.LH = 1; step();
    chk("ovf_regH", int'(dut.reg_h), 144);
    chk("ovf_set", int'(bus.ovf), 1);
    bus.M2 = 2'd1; bus.coef_b = 8'd7; bus.LS = 1; step();
    chk("ovf_sticky_ls_coef", int'(bus.ovf), 1);
    bus.M0 = 2'd3; bus.M1 = 2'd0; bus.H = 0; bus.M2 = 2'd2; bus.LS = 1; step();
    chk("ovf_sticky_ls_alu", int'(bus.ovf), 1);
    chk("add_coef_regS", int'(dut.reg_s), 13);
    // ALU overflow with no load must not flag anything; LX clears
    load_x(4);
    chk("ovf_cleared", int'(bus.ovf), 0);
    bus.M0 = 2'd3; bus.M1 = 2'd3; bus.coef_a = 8'd200; bus.H = 1; step();
    chk("ovf_no_load", int'(bus.ovf), 0);
    // LX with same-cycle overflow on LS: set wins
    bus.M0 = 2'd3; bus.M1 = 2'd3; bus.H = 1; bus.M2 = 2'd0; bus.LS = 1; bus.LX = 1;
    bus.x_in = 8'd4; step();
    chk("ovf_set_beats_clear", int'(bus.ovf), 1);
    chk("ovf_wrap_regS", int'(dut.reg_s), (200 * 13) % 256);
    load_x(4);

    // Backpressure: 20 pending, new pronto with regS = 7 dropped
    bus.M2 = 2'd3; bus.x_in = 8'd20; bus.LS = 1; step();
    bus.pronto = 1; step();
    chk("bp_capture", int'(bus.resultado), 20);
    bus.M2 = 2'd1; bus.coef_b = 8'd7; bus.LS = 1; step();
    bus.pronto = 1; step();
    chk("bp_hold_res", int'(bus.resultado), 20);
    chk("bp_hold_valid", int'(bus.res_valid), 1);
    bus.res_ack = 1; step();
    chk("bp_ack_valid", int'(bus.res_valid), 0);
    chk("bp_ack_res", int'(bus.resultado), 20);
    bus.res_ack = 1; step();
    chk("ack_idle_ignored", int'(bus.res_valid), 0);

    // Simultaneous pronto + ack while valid: new value taken, valid stays 1
    bus.M2 = 2'd3; bus.x_in = 8'd20; bus.LS = 1; step();
    bus.pronto = 1; step();
    bus.M2 = 2'd1; bus.coef_b = 8'd7; bus.LS = 1; step();
    bus.pronto = 1; bus.res_ack = 1; step();
    chk("sim_res", int'(bus.resultado), 7);
    chk("sim_valid", int'(bus.res_valid), 1);
    // pronto held: repeated captures of the same value
    bus.pronto = 1; bus.res_ack = 1; step();
    bus.pronto = 1; bus.res_ack = 1; step();
    chk("held_pronto_res", int'(bus.resultado), 7);
    bus.res_ack = 1; step();

    // Parallel loads from old X = 4: 4+4 = 8 into H and S
    load_x(4);
    bus.M0 = 2'd0; bus.M1 = 2'd1; bus.H = 0; bus.M2 = 2'd0; bus.x_in = 8'd9;
    bus.LX = 1; bus.LH = 1; bus.LS = 1; step();
    chk("par_regX", int'(dut.reg_x), 9);
    chk("par_regH", int'(dut.reg_h), 8);
    chk("par_regS", int'(dut.reg_s), 8);

    // Mid-run reset after step 4, then full rerun
    bus.pronto = 1; step();
    nominal_1_4();
    rst = 1; bus.LX = 1; bus.LS = 1; bus.pronto = 1; step();
    rst = 0;
    chk("mid_rst_regH", int'(dut.reg_h), 0);
    chk("mid_rst_regS", int'(dut.reg_s), 0);
    chk("mid_rst_res", int'(bus.resultado), 0);
    chk("mid_rst_valid", int'(bus.res_valid), 0);
    nominal_1_4();
    nominal_5_6();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
